// File: rtl/s_port_alloc_ctrl.sv
// South output-port allocator: locks the rr processor's grant for one wormhole packet,
// pops flits from the granted input under downstream credit control, and rotates priority per packet.
module s_port_alloc_ctrl #(
  parameter int CREDIT_DEPTH = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       rrp_grant_i,
  input  logic [2:0]       rrp_cs_sel_i,
  input  logic [3:0]       req_valid_i,
  input  logic [3:0]       req_tail_i,
  input  logic             credit_return_i,
  output logic [3:0]       pop_o,
  output logic             flit_send_o,
  output logic [2:0]       cs_sel_o,
  output logic             rr_change_order_o,
  output logic             rr_downstream_credit_o,
  output logic [CNT_W-1:0] credit_cnt_o,
  output logic             credit_err_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    ROTATE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CREDIT_DEPTH);

  state_e           state_q;
  logic [3:0]       lock_q;
  logic [2:0]       cs_sel_q;
  logic             chg_q;
  logic [CNT_W-1:0] credit_q, credit_d;
  logic             err_q, err_d;

  logic       crd_ok;
  logic       onehot;
  logic       accept;
  logic       tail_popped;
  logic [3:0] pop_c;

  assign crd_ok = (credit_q != '0);
  assign onehot = (rrp_grant_i != 4'b0000) && ((rrp_grant_i & (rrp_grant_i - 4'd1)) == 4'b0000);
  assign accept = (state_q == IDLE) && onehot && (|(rrp_grant_i & req_valid_i)) && crd_ok;

  always_comb begin
    pop_c = 4'b0000;
    case (state_q)
      IDLE:    if (accept) pop_c = rrp_grant_i;
      LOCKED:  pop_c = lock_q & req_valid_i & {4{crd_ok}};
      default: pop_c = 4'b0000;
    endcase
  end

  // Pops are suppressed combinationally while reset is held so no flit leaks mid-reset.
  assign pop_o       = reset ? pop_c : 4'b0000;
  assign flit_send_o = |pop_o;
  assign tail_popped = |(pop_o & req_tail_i);

  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    case ({flit_send_o, credit_return_i})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == DEPTH_C) err_d = 1'b1;
        else                     credit_d = credit_q + 1'b1;
      end
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      lock_q   <= 4'b0000;
      cs_sel_q <= 3'b000;
      chg_q    <= 1'b0;
      credit_q <= DEPTH_C;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
      chg_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            lock_q   <= rrp_grant_i;
            cs_sel_q <= rrp_cs_sel_i;
            if (tail_popped) begin
              state_q <= ROTATE;
              chg_q   <= 1'b1;
            end else begin
              state_q <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (tail_popped) begin
            state_q <= ROTATE;
            chg_q   <= 1'b1;
          end
        end
        ROTATE: begin
          lock_q   <= 4'b0000;
          cs_sel_q <= 3'b000;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cs_sel_o               = cs_sel_q;
  assign rr_change_order_o      = chg_q;
  assign rr_downstream_credit_o = crd_ok;
  assign credit_cnt_o           = credit_q;
  assign credit_err_o           = err_q;
  assign busy_o                 = (state_q != IDLE);

endmodule

// File: tb/tb_s_port_alloc_ctrl.sv
// Bench for s_port_alloc_ctrl: directed packet scenarios then random traffic,
// compared each cycle against a packet-level model (owner input, credits, rotate flag).
module tb_s_port_alloc_ctrl;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] grant, valid, tail;
  logic [2:0] sel;
  logic       ret;

  logic [3:0] pop_o;
  logic       flit_send_o;
  logic [2:0] cs_sel_o;
  logic       rr_change_order_o;
  logic       rr_downstream_credit_o;
  logic [2:0] credit_cnt_o;
  logic       credit_err_o;
  logic       busy_o;

  s_port_alloc_ctrl #(.CREDIT_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .rrp_grant_i            (grant),
    .rrp_cs_sel_i           (sel),
    .req_valid_i            (valid),
    .req_tail_i             (tail),
    .credit_return_i        (ret),
    .pop_o                  (pop_o),
    .flit_send_o            (flit_send_o),
    .cs_sel_o               (cs_sel_o),
    .rr_change_order_o      (rr_change_order_o),
    .rr_downstream_credit_o (rr_downstream_credit_o),
    .credit_cnt_o           (credit_cnt_o),
    .credit_err_o           (credit_err_o),
    .busy_o                 (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Packet-level model: which input owns the port (-1 none), rotate cycle pending, credits.
  int         m_owner;
  bit         m_rot;
  logic [2:0] m_cs;
  int         m_cred;
  bit         m_err;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_rot   = 1'b0;
    m_cs    = 3'b000;
    m_cred  = DEPTH;
    m_err   = 1'b0;
  endtask

  function automatic logic [3:0] exp_pop();
    if (m_rot || m_cred == 0) return 4'b0000;
    if (m_owner < 0)
      return (($countones(grant) == 1) && ((grant & valid) != 4'b0000)) ? grant : 4'b0000;
    return valid[m_owner] ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic step();
    logic [3:0] ep;
    int idx;
    bit sent;
    ep   = exp_pop();
    sent = (ep != 4'b0000);
    idx  = 0;
    for (int i = 0; i < 4; i++) if (ep[i]) idx = i;
    #3;
    chk("pop",     8'(pop_o), 8'(ep));
    chk("send",    8'(flit_send_o), 8'(sent));
    chk("cs_sel",  8'(cs_sel_o), 8'(m_cs));
    chk("chg_ord", 8'(rr_change_order_o), 8'(m_rot));
    chk("crd_av",  8'(rr_downstream_credit_o), 8'(m_cred != 0));
    chk("crd_cnt", 8'(credit_cnt_o), 8'(m_cred));
    chk("crd_err", 8'(credit_err_o), 8'(m_err));
    chk("busy",    8'(busy_o), 8'(m_rot || m_owner >= 0));
    @(posedge clk);
    if (m_rot) begin
      m_rot = 1'b0;
      m_cs  = 3'b000;
    end else if (sent) begin
      if (m_owner < 0) begin
        m_owner = idx;
        m_cs    = sel;
      end
      if (tail[idx]) begin
        m_owner = -1;
        m_rot   = 1'b1;
      end
    end
    if (sent && !ret) m_cred--;
    else if (ret && !sent) begin
      if (m_cred == DEPTH) m_err = 1'b1;
      else m_cred++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    grant = 4'b0000; valid = 4'b0000; tail = 4'b0000; sel = 3'b000; ret = 1'b0;
  endtask

  task automatic refill();
    idle_inputs();
    for (int k = 0; k < 8 && m_cred < DEPTH; k++) begin
      ret = 1'b1;
      step();
    end
    ret = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    // Reset held: outputs at reset values even with a legal request present.
    grant = 4'b1000; valid = 4'b1111; tail = 4'b1111;
    @(posedge clk); #1;
    chk("rst_pop",  8'(pop_o), 8'h0);
    chk("rst_send", 8'(flit_send_o), 8'h0);
    chk("rst_cnt",  8'(credit_cnt_o), 8'(DEPTH));
    chk("rst_busy", 8'(busy_o), 8'h0);
    chk("rst_cs",   8'(cs_sel_o), 8'h0);
    chk("rst_chg",  8'(rr_change_order_o), 8'h0);
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b1;

    // Single-flit packet on n.
    grant = 4'b1000; sel = 3'b011; valid = 4'b1000; tail = 4'b1000;
    step();
    chk("sf_chg", 8'(rr_change_order_o), 8'h1);
    chk("sf_cs",  8'(cs_sel_o), 8'h3);
    idle_inputs();
    step();
    step();
    chk("sf_cs_clr", 8'(cs_sel_o), 8'h0);
    chk("sf_cnt",    8'(credit_cnt_o), 8'h3);

    // Three-flit packet from w while the grant wanders to e.
    refill();
    grant = 4'b0100; sel = 3'b010; valid = 4'b0100;
    step();
    grant = 4'b0010; valid = 4'b0110;
    step();
    tail = 4'b0110;
    step();
    idle_inputs();
    step();
    step();

    // Credit exhaustion: 6-flit packet on l with no returns until stalled.
    refill();
    grant = 4'b0001; sel = 3'b001; valid = 4'b0001;
    for (int k = 0; k < 4; k++) step();
    grant = 4'b0000;
    step();
    step();
    chk("ex_crd_av", 8'(rr_downstream_credit_o), 8'h0);
    ret = 1'b1;
    step();
    ret = 1'b0;
    step();
    chk("ex_cnt0", 8'(credit_cnt_o), 8'h0);
    tail = 4'b0001; ret = 1'b1;
    step();
    ret = 1'b0;
    step();
    idle_inputs();
    step();

    // Simultaneous send and return at count 2, then overflow return at full count.
    refill();
    grant = 4'b0010; sel = 3'b100; valid = 4'b0010;
    step();
    step();
    ret = 1'b1;
    step();
    chk("sim_cnt2", 8'(credit_cnt_o), 8'h2);
    tail = 4'b0010;
    step();
    refill();
    ret = 1'b1;
    step();
    ret = 1'b0;
    step();
    chk("ovf_err", 8'(credit_err_o), 8'h1);
    chk("ovf_cnt", 8'(credit_cnt_o), 8'(DEPTH));

    // Bubble on a locked packet, then asynchronous reset mid-packet.
    grant = 4'b0001; sel = 3'b001; valid = 4'b0001;
    step();
    grant = 4'b0000; valid = 4'b0000;
    for (int k = 0; k < 3; k++) step();
    chk("bub_busy", 8'(busy_o), 8'h1);
    #2;
    valid = 4'b0001;
    reset = 1'b0;
    #1;
    chk("arst_pop",  8'(pop_o), 8'h0);
    chk("arst_busy", 8'(busy_o), 8'h0);
    chk("arst_chg",  8'(rr_change_order_o), 8'h0);
    chk("arst_cnt",  8'(credit_cnt_o), 8'(DEPTH));
    chk("arst_err",  8'(credit_err_o), 8'h0);
    chk("arst_cs",   8'(cs_sel_o), 8'h0);
    model_reset();
    idle_inputs();
    @(posedge clk); #1;
    chk("arst_chg2", 8'(rr_change_order_o), 8'h0);
    reset = 1'b1;

    // Non-one-hot grant is ignored.
    grant = 4'b1010; valid = 4'b1111; sel = 3'b111;
    step();
    step();
    chk("inv_busy", 8'(busy_o), 8'h0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 7) grant = 4'b0001 << $urandom_range(0, 3);
      else grant = 4'($urandom_range(0, 15));
      sel   = 3'($urandom_range(0, 7));
      valid = 4'($urandom_range(0, 15));
      tail  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      ret   = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s_port_alloc_ctrl.md
Name: s_port_alloc_ctrl

Overview:
- Controls the south output port of the router. It sits between the south round-robin priority processor and the south crossbar column/downstream link.
- Takes the processor's one-hot grant and locks it for a whole wormhole packet (head to tail), popping flits from the granted input.
- Tracks downstream buffer credits and drives the processor's credit-available input.
- Pulses change-order after each packet tail so the round-robin priority rotates exactly once per packet.

Parameters:
- CREDIT_DEPTH, 4, downstream input-buffer depth in flits; also the credit counter reset value.
- CNT_W, 3, credit counter width; must satisfy 2^CNT_W > CREDIT_DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- rrp_grant_i  input  4  one-hot grant from south rr processor, bit order {n,w,e,l}
- rrp_cs_sel_i  input  3  crossbar select code from south rr processor, valid with rrp_grant_i
- req_valid_i  input  4  input buffer has a flit destined south, {n,w,e,l}
- req_tail_i  input  4  flit at head of input buffer is a tail (single-flit packet = head+tail), {n,w,e,l}
- credit_return_i  input  1  downstream freed one buffer slot this cycle
- pop_o  output  4  one-hot dequeue strobe to the granted input buffer (combinational)
- flit_send_o  output  1  flit crosses the south crossbar/link this cycle (combinational, = |pop_o)
- cs_sel_o  output  3  registered crossbar select for the south column
- rr_change_order_o  output  1  registered one-cycle pulse to the rr registers
- rr_downstream_credit_o  output  1  credit_cnt != 0 (combinational from register)
- credit_cnt_o  output  CNT_W  current credit count
- credit_err_o  output  1  sticky flag: credit return received while count == CREDIT_DEPTH
- busy_o  output  1  state != IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, lock_q=4'b0000, cs_sel_o=3'b000 (no connection), rr_change_order_o=0.
  - credit_cnt=CREDIT_DEPTH, credit_err_o=0.
  - pop_o and flit_send_o are 0 while reset is asserted.
- Definitions:
  - crd_ok = (credit_cnt != 0).
  - onehot = rrp_grant_i has exactly one bit set.
- State IDLE:
  - Accept when onehot & |(rrp_grant_i & req_valid_i) & crd_ok.
  - On accept: pop_o = rrp_grant_i in the same cycle (zero-latency first flit); lock_q<=rrp_grant_i; cs_sel_o<=rrp_cs_sel_i.
  - If the popped flit is a tail, go to ROTATE; otherwise go to LOCKED.
  - A grant that is not one-hot, or whose input has no valid flit, or arrives with no credit, is ignored: stay IDLE, pop_o=0.
- State LOCKED:
  - pop_o = lock_q & req_valid_i & {4{crd_ok}}; rrp_grant_i is ignored.
  - A bubble (valid low) or zero credit holds the lock with no pop.
  - Tail popped: go to ROTATE.
- State ROTATE (exactly one cycle):
  - rr_change_order_o=1, pop_o=0, no grant accepted; lock_q cleared; cs_sel_o<=3'b000; next state IDLE.
  - rr_change_order_o is 1 only in ROTATE.
- Credit counter:
  - Decrement on flit_send_o; increment on credit_return_i; both in the same cycle leaves it unchanged.
  - Never decrements at 0, because sending is gated by crd_ok.
  - Return at CREDIT_DEPTH with no send: count saturates and credit_err_o is set (sticky until reset).
- Reset mid-packet: lock dropped, no change-order pulse, credits restored to CREDIT_DEPTH. The upstream system resets in the same cycle.
- req_tail_i is sampled only for the popped input.

Test Plan:
- Single-flit packet: reset release; rrp_grant_i=4'b1000, rrp_cs_sel_i=3'b011, req_valid_i[3]=1, req_tail_i[3]=1 -> pop_o=4'b1000 same cycle; next cycle state ROTATE with rr_change_order_o=1 and cs_sel_o=3'b011; the cycle after, IDLE and cs_sel_o=3'b000; credit_cnt_o=3.
- 3-flit packet from w with grant switching to e mid-packet: pop_o=4'b0100 on three valid cycles and never 4'b0010; exactly one change_order pulse after the tail.
- Credit exhaustion: CREDIT_DEPTH=4, 6-flit packet, no returns -> 4 pops, then rr_downstream_credit_o=0 and pops stall; one credit_return_i -> exactly one more pop the next cycle.
- Simultaneous send and return with credit_cnt=2: credit_cnt stays 2. Return at count 4 -> count stays 4 and credit_err_o=1 until reset.
- Bubble plus async reset: LOCKED on l with req_valid_i[0] low for 3 cycles -> no pops, lock held. Assert reset mid-packet -> all outputs return to reset values immediately, with no rr_change_order_o pulse.
- Invalid grant: rrp_grant_i=4'b1010 with req_valid_i=4'b1111 -> pop_o=0, state remains IDLE.
